// File: rtl/char_glyph_render_if.sv
// char_glyph_render_if: pixel-stage bundle between the timing generator/row store and char_glyph_render
// master: drives coordinates, active, syncs and char_code; receives rgb, pixel_on and delayed syncs
// slave : the glyph renderer side of the same signals
interface char_glyph_render_if;
  logic [9:0] xcoor;
  logic [8:0] ycoor;
  logic       video_active;
  logic       hsync_in;
  logic       vsync_in;
  logic [5:0] char_code;
  logic [5:0] rgb;
  logic       pixel_on;
  logic       hsync_out;
  logic       vsync_out;
  modport master (
    output xcoor, ycoor, video_active, hsync_in, vsync_in, char_code,
    input  rgb, pixel_on, hsync_out, vsync_out
  );
  modport slave (
    input  xcoor, ycoor, video_active, hsync_in, vsync_in, char_code,
    output rgb, pixel_on, hsync_out, vsync_out
  );
endinterface

// File: rtl/char_glyph_render.sv
// char_glyph_render: font-ROM glyph row lookup producing an RRGGBB pixel with syncs kept aligned
// clk, rst (async, active-high) plain ports; bus.slave carries xcoor/ycoor/video_active/hsync_in/
// vsync_in/char_code in and rgb/pixel_on/hsync_out/vsync_out out
module char_glyph_render #(
  parameter int         CHAR_LAT = 2,
  parameter int         Y_START  = 100,
  parameter int         X_START  = 0,
  parameter logic [5:0] FG_RGB   = 6'b111111,
  parameter logic [5:0] BG_RGB   = 6'b000001
) (
  input logic clk,
  input logic rst,
  char_glyph_render_if.slave bus
);
  localparam int DW = 22;
  localparam int SW = CHAR_LAT * DW;
  logic [SW-1:0] sr;
  logic [9:0]  x_d;
  logic [8:0]  y_d;
  logic        a_d, hs_d, vs_d;
  logic [11:0] ys;
  logic        in_win;
  logic [55:0] glyph;
  logic [7:0]  row_bits;
  logic [7:0]  g1;
  logic [2:0]  c1;
  logic        w1, b1, a1, hs1, vs1;
  logic        bit_on;
  // rows 1..7 of each glyph, row 1 in the top byte; rows 0, 8, 9 are always blank
  function automatic logic [55:0] font(input logic [5:0] code);
    case (code)
      6'd0:  font = 56'h3C666E7666663C;
      6'd1:  font = 56'h1838181818187E;
      6'd2:  font = 56'h3C66060C30607E;
      6'd3:  font = 56'h3C66061C06663C;
      6'd4:  font = 56'h0C1C3C6C7E0C0C;
      6'd5:  font = 56'h7E607C0606663C;
      6'd6:  font = 56'h3C607C6666663C;
      6'd7:  font = 56'h7E060C18303030;
      6'd8:  font = 56'h3C66663C66663C;
      6'd9:  font = 56'h3C66663E06663C;
      6'd10: font = 56'h183C66667E6666;
      6'd11: font = 56'h7C66667C66667C;
      6'd12: font = 56'h3C66606060663C;
      6'd13: font = 56'h786C6666666C78;
      6'd14: font = 56'h7E60607860607E;
      6'd15: font = 56'h7E606078606060;
      6'd16: font = 56'h3C66606E66663C;
      6'd17: font = 56'h6666667E666666;
      6'd18: font = 56'h3C18181818183C;
      6'd19: font = 56'h1E0C0C0C0C6C38;
      6'd20: font = 56'h666C7870786C66;
      6'd21: font = 56'h6060606060607E;
      6'd22: font = 56'h63777F6B636363;
      6'd23: font = 56'h66767E7E6E6666;
      6'd24: font = 56'h3C66666666663C;
      6'd25: font = 56'h7C66667C606060;
      6'd26: font = 56'h3C666666663C0E;
      6'd27: font = 56'h7C66667C786C66;
      6'd28: font = 56'h3C66603C06663C;
      6'd29: font = 56'h7E181818181818;
      6'd30: font = 56'h6666666666663C;
      6'd31: font = 56'h66666666663C18;
      6'd32: font = 56'h6363636B7F7763;
      6'd33: font = 56'h66663C183C6666;
      6'd34: font = 56'h6666663C181818;
      6'd35: font = 56'h7E060C1830607E;
      default: font = 56'h0;
    endcase
  endfunction
  // coordinate/sync delay line so its head lines up with the row store's char_code
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else sr <= SW'({sr, bus.xcoor, bus.ycoor, bus.video_active, bus.hsync_in, bus.vsync_in});
  assign {x_d, y_d, a_d, hs_d, vs_d} = sr[SW-1 -: DW];
  // sign bit of the widened difference rejects lines above the row before the offset is used
  always_comb begin
    ys = {3'b0, y_d} - 12'(Y_START);
    in_win = !ys[11] && (ys[10:0] <= 11'd9) && ($signed({1'b0, x_d}) >= $signed(11'(X_START)));
    glyph = font(bus.char_code);
    row_bits = (in_win && ys[3:0] != 4'd0 && !ys[3]) ? 8'(glyph >> {3'd7 - ys[2:0], 3'b000}) : 8'd0;
  end
  assign bit_on = g1[3'd7 - c1];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      g1 <= '0;
      c1 <= '0;
      w1 <= 1'b0;
      b1 <= 1'b0;
      a1 <= 1'b0;
      hs1 <= 1'b0;
      vs1 <= 1'b0;
      bus.rgb <= '0;
      bus.pixel_on <= 1'b0;
      bus.hsync_out <= 1'b0;
      bus.vsync_out <= 1'b0;
    end else begin
      g1 <= row_bits;
      c1 <= x_d[2:0] - 3'(X_START);
      w1 <= in_win;
      b1 <= bus.char_code == 6'd63;
      a1 <= a_d;
      hs1 <= hs_d;
      vs1 <= vs_d;
      bus.pixel_on <= a1 & w1 & ~b1 & bit_on;
      bus.rgb <= (a1 & w1 & ~b1) ? (bit_on ? FG_RGB : BG_RGB) : 6'd0;
      bus.hsync_out <= hs1;
      bus.vsync_out <= vs1;
    end
endmodule
